alu_pg_pipe: RTL and testbench
==============================

// Module: alu_pg_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined 74181-style ALU. Stage 1 registers per-bit
//  select-function propagate/generate (P/G); stage 2 resolves carries by 4-bit
//  group lookahead, forms the result, and applies flags. Valid/ready on both
//  sides; optional carry chaining for multi-word arithmetic. Successor to the
//  fixed 4-bit P/G submodule.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of GROUP (>=4)
//  GROUP   4  lookahead group size in bits
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operation offered
//  in_ready   out  1      stage 1 can accept
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_s       in   4      function select S3..S0
//  in_m       in   1      1 = logic mode (no carries), 0 = arithmetic
//  in_cin     in   1      carry in, active-high
//  in_chain   in   1      1 = use chained carry instead of in_cin
//  out_valid  out  1      result held
//  out_ready  in   1      consumer accepts
//  out_f      out  WIDTH  result F
//  out_cout   out  1      carry out of bit WIDTH-1 (0 when in_m=1)
//  out_ovf    out  1      c[WIDTH] ^ c[WIDTH-1] (0 when in_m=1)
//  out_aeqb   out  1      &out_f
//  out_gp     out  1      word propagate (&~P), for external lookahead
//  out_gg     out  1      word generate (carry-out assuming cin=0)
// BEHAVIOUR
//  Per bit: P_i = ~(A_i | B_i&S0 | ~B_i&S1); G_i = ~(A_i&~B_i&S2 | A_i&B_i&S3).
//  Carry: c_0 = cin_eff; c_{i+1} = ~G_i | (~P_i & c_i); computed per GROUP
//   block lookahead, rippled between groups (result must equal bitwise ripple).
//  Result: F_i = P_i ^ G_i ^ (~M & c_i).
//  Stage 1 (s1): on in_valid&in_ready load P,G,M,cin,chain; s1_valid<=1.
//  Stage 2 (s2): on s1_valid & (~out_valid | out_ready) compute and register
//   outputs; out_valid<=1. out_valid clears when out_ready and no s2 load.
//  in_ready = ~s1_valid | s2 load this cycle (full throughput, bubble collapse).
//  Latency: 2 cycles in-accept -> out_valid, with out_ready held high.
//  Chain carry register: cin_eff = s1_chain ? chain_c : s1_cin. chain_c <=
//   computed cout on every s2 load (M=1 loads 0). Thus chain refers to the
//   previous op in program order, regardless of stalls.
//  Stall: out_valid&~out_ready freezes s2 and all out_*; s1 holds if full.
//  Outputs stable while out_valid&~out_ready; no transaction dropped/duplicated.
//  Reset (any time, incl. mid-transfer): s1_valid, out_valid, chain_c, out_f,
//   out_cout, out_ovf, out_aeqb, out_gp, out_gg all 0; in_ready 1 after
//   release; in-flight ops discarded.
// TESTING
//  Add: S=1001,M=0,cin=0,A=0x0035,B=0x000C -> F=0x0041,cout=0,ovf=0, 2 cycles.
//  Sub: S=0110,M=0,cin=1,A=0x0010,B=0x0001 -> F=0x000F,cout=1; A=0,B=1 ->
//   F=0xFFFF,cout=0,aeqb=1.
//  Logic: S=1001,M=1,A=0xF0F0,B=0xFF00 -> F=0x0FF0,cout=0,ovf=0.
//  Chain: add 0xFFFF+0x0001 (cin=0) then chain op 0x0000+0x0000 -> 0x0000/
//   cout=1, then 0x0001/cout=0; repeat with out_ready low 5 cycles between.
//  Backpressure: 4 back-to-back ops, out_ready=0 for 3 cycles -> in_ready=0
//   after 2 accepts, outputs frozen, all 4 results in order, none lost.
//  Reset mid-stream with s1/s2 full -> out_valid=0, chain_c=0 next op uses cin.

Source files
------------

// File: rtl/alu_pg_pipe.sv
// Two-stage pipelined 74181-style ALU: stage 1 registers per-bit P/G,
// stage 2 resolves carries by group lookahead and registers result and flags.
module alu_pg_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_s,
    input  logic             in_m,
    input  logic             in_cin,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_aeqb,
    output logic             out_gp,
    output logic             out_gg
);

    localparam int unsigned NGRP = WIDTH / GROUP;

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             m_q, m_d;
    logic             cin_q, cin_d;
    logic             chain_q, chain_d;

    // Stage 2 / output state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             aeqb_q, aeqb_d;
    logic             gp_q, gp_d;
    logic             gg_q, gg_d;
    logic             chain_c_q, chain_c_d;

    logic             in_fire;
    logic             s2_load;

    // Stage 2 combinational results
    logic [WIDTH-1:0] gen_w, prop_w;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] f_c;
    logic             cin_eff;
    logic             grp_gen, grp_prop;
    logic             gg_acc, gp_acc;

    assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign in_fire  = in_valid & in_ready;

    // Stage 1: per-bit select-function propagate/generate
    always_comb begin
        s1_valid_d = s1_valid_q;
        p_d        = p_q;
        g_d        = g_q;
        m_d        = m_q;
        cin_d      = cin_q;
        chain_d    = chain_q;
        if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            p_d        = ~(in_a | (in_b & {WIDTH{in_s[0]}}) | (~in_b & {WIDTH{in_s[1]}}));
            g_d        = ~((in_a & ~in_b & {WIDTH{in_s[2]}}) | (in_a & in_b & {WIDTH{in_s[3]}}));
            m_d        = in_m;
            cin_d      = in_cin;
            chain_d    = in_chain;
        end
    end

    // Stage 2: group lookahead inside each block, ripple between blocks
    always_comb begin
        gen_w    = ~g_q;
        prop_w   = ~p_q;
        cin_eff  = chain_q ? chain_c_q : cin_q;
        c        = '0;
        c[0]     = cin_eff;
        grp_gen  = 1'b0;
        grp_prop = 1'b1;
        gg_acc   = 1'b0;
        gp_acc   = 1'b1;
        for (int unsigned grp = 0; grp < NGRP; grp++) begin
            grp_gen  = 1'b0;
            grp_prop = 1'b1;
            for (int unsigned k = 0; k < GROUP; k++) begin
                if (k != 0) begin
                    c[grp*GROUP + k] = grp_gen | (grp_prop & c[grp*GROUP]);
                end
                grp_gen  = gen_w[grp*GROUP + k] | (prop_w[grp*GROUP + k] & grp_gen);
                grp_prop = grp_prop & prop_w[grp*GROUP + k];
            end
            c[grp*GROUP + GROUP] = grp_gen | (grp_prop & c[grp*GROUP]);
            gg_acc = grp_gen | (grp_prop & gg_acc);
            gp_acc = gp_acc & grp_prop;
        end
        f_c = p_q ^ g_q ^ ({WIDTH{~m_q}} & c[WIDTH-1:0]);
    end

    // Output register and chain carry update
    always_comb begin
        out_valid_d = out_valid_q;
        f_d         = f_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        aeqb_d      = aeqb_q;
        gp_d        = gp_q;
        gg_d        = gg_q;
        chain_c_d   = chain_c_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            f_d         = f_c;
            cout_d      = ~m_q & c[WIDTH];
            ovf_d       = ~m_q & (c[WIDTH] ^ c[WIDTH-1]);
            aeqb_d      = &f_c;
            gp_d        = gp_acc;
            gg_d        = gg_acc;
            chain_c_d   = ~m_q & c[WIDTH];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            p_q         <= '0;
            g_q         <= '0;
            m_q         <= 1'b0;
            cin_q       <= 1'b0;
            chain_q     <= 1'b0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            aeqb_q      <= 1'b0;
            gp_q        <= 1'b0;
            gg_q        <= 1'b0;
            chain_c_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            p_q         <= p_d;
            g_q         <= g_d;
            m_q         <= m_d;
            cin_q       <= cin_d;
            chain_q     <= chain_d;
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            aeqb_q      <= aeqb_d;
            gp_q        <= gp_d;
            gg_q        <= gg_d;
            chain_c_q   <= chain_c_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_f     = f_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_aeqb  = aeqb_q;
    assign out_gp    = gp_q;
    assign out_gg    = gg_q;

endmodule

// File: tb/tb_alu_pg_pipe.sv
// Bench for alu_pg_pipe: arithmetic reference model (X + Y + cin) with
// program-order chain carry, scoreboard of expected vs observed results.
module tb_alu_pg_pipe;

    typedef struct packed {
        logic [15:0] f;
        logic        cout;
        logic        ovf;
        logic        aeqb;
        logic        gp;
        logic        gg;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic [3:0]  in_s;
    logic        in_m, in_cin, in_chain;
    logic        out_valid, out_ready;
    logic [15:0] out_f;
    logic        out_cout, out_ovf, out_aeqb, out_gp, out_gg;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t obs_q[$];
    logic model_chain = 1'b0;

    always #5 clk = ~clk;

    alu_pg_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m),
        .in_cin(in_cin), .in_chain(in_chain),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_aeqb(out_aeqb), .out_gp(out_gp), .out_gg(out_gg)
    );

    // Record every completed output handshake
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready)
            obs_q.push_back(res_t'({out_f, out_cout, out_ovf, out_aeqb, out_gp, out_gg}));
    end

    // X = per-bit propagate word, Y = generate word (Y implies X), so the
    // arithmetic result is simply X + Y + cin and the logic result X ^ Y.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] s, input logic m, input logic cin);
        res_t        r;
        logic [15:0] x, y, low;
        logic [16:0] sum, sum0;
        x    = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
        y    = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
        sum  = {1'b0, x} + {1'b0, y} + 17'(cin);
        sum0 = {1'b0, x} + {1'b0, y};
        low  = {1'b0, x[14:0]} + {1'b0, y[14:0]} + 16'(cin);
        r.f    = m ? (x ^ y) : sum[15:0];
        r.cout = m ? 1'b0 : sum[16];
        r.ovf  = m ? 1'b0 : (sum[16] ^ low[15]);
        r.aeqb = &r.f;
        r.gp   = &x;
        r.gg   = sum0[16];
        return r;
    endfunction

    task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                            input logic m, input logic cin, input logic chain);
        logic acc;
        int   n;
        in_a = a; in_b = b; in_s = s; in_m = m; in_cin = cin; in_chain = chain;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1 within 200 cycles", in_ready);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic m, input logic cin, input logic chain);
        res_t r;
        r = model(a, b, s, m, chain ? model_chain : cin);
        exp_q.push_back(r);
        model_chain = r.cout;
        drive_op(a, b, s, m, cin, chain);
    endtask

    task automatic wait_drain(output logic ok);
        int n;
        out_ready = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            @(posedge clk);
            #1;
            ok = (obs_q.size() == exp_q.size()) && !out_valid;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0;
        in_m = 1'b0; in_cin = 1'b0; in_chain = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++;
        if (out_f !== 16'h0) begin errors++; $display("FAIL reset_out_f: got %h required 0000", out_f); end
        checks++;
        if ({out_cout, out_ovf, out_aeqb, out_gp, out_gg} !== 5'b0)
        begin
            errors++;
            $display("FAIL reset_flags: got cout/ovf/aeqb/gp/gg=%b required 00000",
                     {out_cout, out_ovf, out_aeqb, out_gp, out_gg});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic ok;
        res_t e, o;
        out_ready = 1'b1;
        issue(16'h0035, 16'h000C, 4'b1001, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_early: out_valid=%b required 0", out_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_f !== 16'h0041 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got v=%b f=%h cout=%b ovf=%b required v=1 f=0041 cout=0 ovf=0",
                     out_valid, out_f, out_cout, out_ovf);
        end
        issue(16'h0010, 16'h0001, 4'b0110, 1'b0, 1'b1, 1'b0);
        issue(16'h0000, 16'h0001, 4'b0110, 1'b0, 1'b1, 1'b0);
        issue(16'hF0F0, 16'hFF00, 4'b1001, 1'b1, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL directed_drain: observed %0d results required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL directed_result: got %h required %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_chain();
        logic ok;
        res_t e, o;
        for (int rep = 0; rep < 2; rep++) begin
            out_ready = 1'b1;
            issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
            if (rep == 1) begin
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
            end
            issue(16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b0, 1'b1);
            if (rep == 1) begin
                repeat (5) @(posedge clk);
                #1;
            end
            wait_drain(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL chain_drain: observed %0d required %0d", obs_q.size(), exp_q.size()); end
            if (obs_q.size() == 2) begin
                checks++;
                if (obs_q[0].f !== 16'h0000 || obs_q[0].cout !== 1'b1 ||
                    obs_q[1].f !== 16'h0001 || obs_q[1].cout !== 1'b0) begin
                    errors++;
                    $display("FAIL chain_values: got %h/%b then %h/%b required 0000/1 then 0001/0",
                             obs_q[0].f, obs_q[0].cout, obs_q[1].f, obs_q[1].cout);
                end
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if (o !== e) begin errors++; $display("FAIL chain_result: got %h required %h", o, e); end
            end
            exp_q.delete();
            obs_q.delete();
        end
    endtask

    task automatic test_random();
        logic ok;
        logic done;
        res_t e, o;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    issue(16'($urandom()), 16'($urandom()), 4'($urandom()),
                          1'($urandom_range(0, 3) == 0), 1'($urandom()),
                          1'($urandom_range(0, 2) == 0));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2;
                    out_ready = 1'($urandom_range(0, 2) != 0);
                end
            end
        join
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL random_drain: observed %0d required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL random_result: got %h required %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic ok;
        res_t e, o;
        int   n_obs;
        out_ready = 1'b0;
        issue(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0, 1'b0);
        issue(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b1, 1'b0);
        in_a = 16'h00FF; in_b = 16'h0F0F; in_s = 4'b0110; in_m = 1'b0; in_cin = 1'b1; in_chain = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_f !== exp_q[0].f || out_cout !== exp_q[0].cout) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d in_ready=%b v=%b f=%h cout=%b required 0/1/%h/%b",
                         k, in_ready, out_valid, out_f, out_cout, exp_q[0].f, exp_q[0].cout);
            end
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        issue(16'h00FF, 16'h0F0F, 4'b0110, 1'b0, 1'b1, 1'b0);
        issue(16'hAAAA, 16'h5555, 4'b0011, 1'b1, 1'b0, 1'b0);
        wait_drain(ok);
        n_obs = obs_q.size();
        checks++;
        if (!ok || n_obs != 4) begin errors++; $display("FAIL b2b_count: observed %0d required 4", n_obs); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_result: got %h required %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        logic ok;
        res_t e, o;
        out_ready = 1'b0;
        issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
        issue(16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_f !== 16'h0 || out_cout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: v=%b f=%h cout=%b required 0/0000/0", out_valid, out_f, out_cout);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_after: in_ready=%b v=%b observed=%0d required 1/0/0",
                     in_ready, out_valid, obs_q.size());
        end
        exp_q.delete();
        obs_q.delete();
        model_chain = 1'b0;
        out_ready = 1'b1;
        issue(16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b1, 1'b1);
        issue(16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b1, 1'b0);
        wait_drain(ok);
        checks++;
        if (!ok || obs_q.size() != 2) begin
            errors++;
            $display("FAIL midreset_drain: observed %0d required 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].f !== 16'h0000 || obs_q[1].f !== 16'h0001) begin
                errors++;
                $display("FAIL midreset_chain: got %h then %h required 0000 then 0001", obs_q[0].f, obs_q[1].f);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL midreset_result: got %h required %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_chain();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
